alu_z_capture: RTL and testbench

Result-capture stage directly downstream of the 32-bit ALU. It accepts a start request with the ALU control code and holds off capture until the ALU output has settled. Multiply and divide get a programmable settle window. It then latches the 64-bit ALU result into the Z register and, for mul/div, into HI/LO. The control unit sees a busy/done handshake, and the datapath bus reads Z, HI, LO and status flags.

---
 rtl/alu_z_capture.sv | 123 ++++++++++++
 tb/tb_alu_z_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_z_capture.sv
// alu_z_capture: result-capture stage behind the 32-bit ALU.
// Waits for the ALU output to settle, then latches the 64-bit result into
// Z and, for mul/div, into HI/LO.
// Handshake: busy while the capture is in progress, and a one-cycle done pulse.
// Optional feature macro: ALU_FLAGS_EN builds the zero/negative flag registers.
// When the macro is undefined, zero_flag and neg_flag are tied to 0.
module alu_z_capture #(
    parameter int REG_SIZE    = 32,
    parameter int MULDIV_WAIT = 4   // settle cycles for mul/div, legal 1..15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              ctrl_sig,
    input  logic [2*REG_SIZE-1:0]   alu_result,
    output logic                    busy,
    output logic                    done,
    output logic                    illegal_op,
    output logic [REG_SIZE-1:0]     z_hi,
    output logic [REG_SIZE-1:0]     z_lo,
    output logic [REG_SIZE-1:0]     hi_out,
    output logic [REG_SIZE-1:0]     lo_out,
    output logic                    zero_flag,
    output logic                    neg_flag
);

    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_DIV   = 4'b1001;
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] op_q;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Opcodes 1100..1111 have no ALU function behind them.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    assign busy = (state != IDLE);

    // Control FSM plus the Z/HI/LO result registers and the registered handshake pulses.
    // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_q       <= 4'd0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
            z_hi       <= '0;
            z_lo       <= '0;
            hi_out     <= '0;
            lo_out     <= '0;
        end else begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= ctrl_sig;
                        if (is_muldiv(ctrl_sig)) begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (is_illegal(op_q)) begin
                        illegal_op <= 1'b1;
                    end else begin
                        z_hi <= alu_result[2*REG_SIZE-1:REG_SIZE];
                        z_lo <= alu_result[REG_SIZE-1:0];
                        if (is_muldiv(op_q)) begin
                            hi_out <= alu_result[2*REG_SIZE-1:REG_SIZE];
                            lo_out <= alu_result[REG_SIZE-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    // Status flags follow the low word being captured, and only for legal opcodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (state == CAPTURE && !is_illegal(op_q)) begin
            zero_flag <= (alu_result[REG_SIZE-1:0] == '0);
            neg_flag  <= alu_result[REG_SIZE-1];
        end
    end
`else
    // Flags are not built in this configuration.
    assign zero_flag = 1'b0;
    assign neg_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_z_capture.sv
// Self-checking bench for alu_z_capture.
// Defaults: REG_SIZE=32, MULDIV_WAIT=4.
// The expected flag values follow ALU_FLAGS_EN.
module tb_alu_z_capture;

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ctrl_sig = 4'b0000;
    logic [63:0] alu_result = '0;
    logic        busy, done, illegal_op, zero_flag, neg_flag;
    logic [31:0] z_hi, z_lo, hi_out, lo_out;

    int errors = 0;
    int checks = 0;

    alu_z_capture #(.REG_SIZE(32), .MULDIV_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ctrl_sig   (ctrl_sig),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .illegal_op (illegal_op),
        .z_hi       (z_hi),
        .z_lo       (z_lo),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] res;
        int          lat;   // edges from the start edge to the done edge
        int          bsy;   // cycles with busy high
        logic [31:0] zh, zl, hi, lo;
        logic        ill, zf, nf;
    } vec_t;

    vec_t vecs[8];

    // Issue one request and wait for done. The latency and busy count come back to the caller.
    task automatic run_op(input logic [3:0] op, input logic [63:0] res,
                          output int lat, output int bsy, output bit timed_out);
        ctrl_sig   = op;
        alu_result = res;
        start      = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        lat       = 0;
        bsy       = 0;
        timed_out = 1'b0;
        while (!done) begin
            if (busy) bsy++;
            if (lat >= 40) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int   lat, bsy, ndone;
        bit   to;
        string tag;

        vecs[0] = '{4'b0010, 64'h0000_0001_0000_0000, 1, 1,
                    32'h0000_0001, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFE, 5, 5,
                    32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4'b1110, 64'h1234_5678_9ABC_DEF0, 1, 1,
                    32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{4'b1001, 64'h0000_0003_0000_0007, 5, 5,
                    32'h0000_0003, 32'h0000_0007, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0000, 64'h0000_0000_8000_0000, 1, 1,
                    32'h0000_0000, 32'h8000_0000, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'b0011, 64'h0000_0000_0000_0000, 1, 1,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'b1111, 64'hAAAA_AAAA_5555_5555, 1, 1,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{4'b0111, 64'hDEAD_BEEF_0000_0001, 1, 1,
                    32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 1'b0};

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        check("rst z", {z_hi, z_lo}, 64'h0);
        check("rst hilo", {hi_out, lo_out}, 64'h0);
        check("rst ctl", {59'h0, busy, done, illegal_op, zero_flag, neg_flag}, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            tag = $sformatf("v%0d", i);
            run_op(vecs[i].op, vecs[i].res, lat, bsy, to);
            check({tag, " timeout"}, 64'(to), 64'h0);
            check({tag, " latency"}, 64'(lat), 64'(vecs[i].lat));
            check({tag, " busy_cycles"}, 64'(bsy), 64'(vecs[i].bsy));
            check({tag, " busy_at_done"}, 64'(busy), 64'h0);
            check({tag, " illegal_op"}, 64'(illegal_op), 64'(vecs[i].ill));
            check({tag, " z"}, {z_hi, z_lo}, {vecs[i].zh, vecs[i].zl});
            check({tag, " hilo"}, {hi_out, lo_out}, {vecs[i].hi, vecs[i].lo});
            check({tag, " flags"}, {62'h0, zero_flag, neg_flag},
                  {62'h0, FLAGS_ON & vecs[i].zf, FLAGS_ON & vecs[i].nf});
            @(posedge clk); #1;
            check({tag, " done_after"}, {62'h0, done, illegal_op}, 64'h0);
        end

        // A start pulse during the div wait is ignored, so only one done appears.
        ctrl_sig   = 4'b1001;
        alu_result = 64'h0000_0009_0000_0002;
        start      = 1'b1;
        ndone      = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            start = (c == 1);
            if (done) ndone++;
        end
        check("busy_start dones", 64'(ndone), 64'd1);
        check("busy_start hilo", {hi_out, lo_out}, 64'h0000_0009_0000_0002);

        // A start issued in the done cycle is accepted.
        ctrl_sig   = 4'b0010;
        alu_result = 64'h0000_0000_0000_0011;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b done1", 64'(done), 64'h1);
        check("b2b z1", {z_hi, z_lo}, 64'h0000_0000_0000_0011);
        ctrl_sig   = 4'b0001;
        alu_result = 64'h0000_0000_0000_0005;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accepted", {62'h0, busy, done}, 64'h2);
        @(posedge clk); #1;
        check("b2b done2", 64'(done), 64'h1);
        check("b2b z2", {z_hi, z_lo}, 64'h0000_0000_0000_0005);
        @(posedge clk); #1;

        // Asynchronous reset two cycles into a mul wait
        ctrl_sig   = 4'b1000;
        alu_result = 64'h7777_7777_8888_8888;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst z", {z_hi, z_lo}, 64'h0);
        check("arst hilo", {hi_out, lo_out}, 64'h0);
        check("arst ctl", {59'h0, busy, done, illegal_op, zero_flag, neg_flag}, 64'h0);
        @(posedge clk); #1;
        rst   = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("arst no_done", 64'(ndone), 64'h0);

        // The first operation after reset release behaves normally.
        run_op(4'b1011, 64'h0000_0000_FFFF_FFF0, lat, bsy, to);
        check("post_rst timeout", 64'(to), 64'h0);
        check("post_rst latency", 64'(lat), 64'd1);
        check("post_rst z", {z_hi, z_lo}, 64'h0000_0000_FFFF_FFF0);
        check("post_rst hilo", {hi_out, lo_out}, 64'h0);
        check("post_rst flags", {62'h0, zero_flag, neg_flag}, {62'h0, 1'b0, FLAGS_ON});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
